// File: rtl/snake_row_scanner_pkg.sv
// Shared constants and types for the snake row scanner.
//   DEF_*         : default grid geometry and packed piece count
//   COLOR_*       : 3-3-2 RGB colours for each cell class
//   scan_state_e  : row-scan sequencer states
//   pix_flags_t   : per-pixel classification fed to the colour mux
package snake_row_scanner_pkg;

  localparam int unsigned DEF_GRID_WIDTH       = 16;
  localparam int unsigned DEF_GRID_HEIGHT      = 12;
  localparam int unsigned DEF_NUM_SNAKE_PIECES = 8;

  localparam logic [7:0] COLOR_BORDER     = 8'b010_010_01;
  localparam logic [7:0] COLOR_FOOD       = 8'b111_000_00;
  localparam logic [7:0] COLOR_HEAD       = 8'b111_111_00;
  localparam logic [7:0] COLOR_BODY       = 8'b000_111_00;
  localparam logic [7:0] COLOR_BACKGROUND = 8'b000_000_00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_COMMIT
  } scan_state_e;

  typedef struct packed {
    logic visible;
    logic border;
    logic food;
    logic head;
    logic body;
  } pix_flags_t;

endpackage

// File: rtl/snake_row_scanner_if.sv
// Bundle of the scanner's data/handshake signals.
//   master : drives snake/food positions, LineStart/RowY, PixelValid/CellX
//   slave  : the scanner; drives RGB, Busy, ScanDone
interface snake_row_scanner_if #(
  parameter int unsigned GRID_WIDTH       = 16,
  parameter int unsigned GRID_HEIGHT      = 12,
  parameter int unsigned NUM_SNAKE_PIECES = 8
);
  localparam int unsigned XB = $clog2(GRID_WIDTH);
  localparam int unsigned YB = $clog2(GRID_HEIGHT);

  logic [YB*NUM_SNAKE_PIECES-1:0] packSnakeY;
  logic [XB*NUM_SNAKE_PIECES-1:0] packSnakeX;
  logic [YB-1:0]                  foodY;
  logic [XB-1:0]                  foodX;
  logic                           LineStart;
  logic [YB-1:0]                  RowY;
  logic                           PixelValid;
  logic [XB-1:0]                  CellX;
  logic [0:7]                     RGB;
  logic                           Busy;
  logic                           ScanDone;

  modport master (
    output packSnakeY, packSnakeX, foodY, foodX, LineStart, RowY, PixelValid, CellX,
    input  RGB, Busy, ScanDone
  );

  modport slave (
    input  packSnakeY, packSnakeX, foodY, foodX, LineStart, RowY, PixelValid, CellX,
    output RGB, Busy, ScanDone
  );
endinterface

// File: rtl/snake_row_scanner_cell_color_mux.sv
// cell_color_mux: combinational priority colour select for one pixel.
//   flags : pixel classification (visible, border, food, head, body)
//   color : 3-3-2 colour; border > food > head > body > background,
//           forced to background when the pixel is not visible
module cell_color_mux
  import snake_row_scanner_pkg::*;
(
  input  pix_flags_t  flags,
  output logic [7:0]  color
);

  always_comb begin
    color = COLOR_BACKGROUND;
    if (!flags.visible) begin
      color = COLOR_BACKGROUND;
    end else if (flags.border) begin
      color = COLOR_BORDER;
    end else if (flags.food) begin
      color = COLOR_FOOD;
    end else if (flags.head) begin
      color = COLOR_HEAD;
    end else if (flags.body) begin
      color = COLOR_BODY;
    end
  end

endmodule

// File: rtl/snake_row_scanner.sv
// snake_row_scanner: builds a per-row occupancy bitmap of the snake one
// piece per cycle, commits it atomically to display registers, and
// colours pixels from the committed row.
//   Clock  : rising-edge clock
//   ResetN : asynchronous active-low reset
//   bus    : slave side of snake_row_scanner_if (positions, LineStart/RowY,
//            PixelValid/CellX in; RGB, Busy, ScanDone out)
module snake_row_scanner
  import snake_row_scanner_pkg::*;
#(
  parameter int unsigned GRID_WIDTH       = DEF_GRID_WIDTH,
  parameter int unsigned GRID_HEIGHT      = DEF_GRID_HEIGHT,
  parameter int unsigned NUM_SNAKE_PIECES = DEF_NUM_SNAKE_PIECES
) (
  input  logic Clock,
  input  logic ResetN,
  snake_row_scanner_if.slave bus
);

  localparam int unsigned XB = $clog2(GRID_WIDTH);
  localparam int unsigned YB = $clog2(GRID_HEIGHT);
  localparam int unsigned IW = $clog2(NUM_SNAKE_PIECES + 1);

  localparam logic [XB:0]   X_LIMIT  = (XB+1)'(GRID_WIDTH);
  localparam logic [XB-1:0] X_LAST   = XB'(GRID_WIDTH - 1);
  localparam logic [YB:0]   Y_LIMIT  = (YB+1)'(GRID_HEIGHT);
  localparam logic [YB:0]   Y_LAST   = (YB+1)'(GRID_HEIGHT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_SNAKE_PIECES - 1);

  scan_state_e state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [YB-1:0]         row_q, row_d;
  logic [GRID_WIDTH-1:0] back_body_q, back_body_d;
  logic [GRID_WIDTH-1:0] back_head_q, back_head_d;

  // Display registers; disp_row is one bit wider so it can hold GRID_HEIGHT,
  // the "no row committed" value that suppresses the border.
  logic [GRID_WIDTH-1:0] disp_body_q, disp_body_d;
  logic [GRID_WIDTH-1:0] disp_head_q, disp_head_d;
  logic [YB:0]           disp_row_q, disp_row_d;
  logic                  disp_food_q, disp_food_d;
  logic [XB-1:0]         disp_food_x_q, disp_food_x_d;

  logic                  scan_done_q, scan_done_d;
  logic [7:0]            rgb_q, rgb_d;

  logic [YB-1:0] piece_y;
  logic [XB-1:0] piece_x;
  logic          row_valid;
  logic          piece_hit;
  logic          disp_row_valid;
  pix_flags_t    pix_flags;
  logic [7:0]    pix_color;

  // Current piece selection and hit test against the latched row.
  always_comb begin
    piece_y   = bus.packSnakeY[int'(idx_q)*YB +: YB];
    piece_x   = bus.packSnakeX[int'(idx_q)*XB +: XB];
    row_valid = {1'b0, row_q} < Y_LIMIT;
    piece_hit = row_valid && (piece_y == row_q) && (piece_x != '0) &&
                ({1'b0, piece_x} < X_LIMIT);
  end

  // Scan sequencer. LineStart restarts from piece 0 in every state, which
  // also covers the abort-without-commit case during SCAN/COMMIT.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    row_d         = row_q;
    back_body_d   = back_body_q;
    back_head_d   = back_head_q;
    disp_body_d   = disp_body_q;
    disp_head_d   = disp_head_q;
    disp_row_d    = disp_row_q;
    disp_food_d   = disp_food_q;
    disp_food_x_d = disp_food_x_q;
    scan_done_d   = 1'b0;

    if (bus.LineStart) begin
      state_d     = ST_SCAN;
      idx_d       = '0;
      row_d       = bus.RowY;
      back_body_d = '0;
      back_head_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_SCAN: begin
          if (piece_hit) begin
            back_body_d[piece_x] = 1'b1;
            if (idx_q == '0) begin
              back_head_d[piece_x] = 1'b1;
            end
          end
          if (idx_q == IDX_LAST) begin
            state_d = ST_COMMIT;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        ST_COMMIT: begin
          disp_body_d   = back_body_q;
          disp_head_d   = back_head_q;
          disp_row_d    = {1'b0, row_q};
          disp_food_d   = row_valid && (bus.foodY == row_q) &&
                          ({1'b0, bus.foodX} < X_LIMIT);
          disp_food_x_d = bus.foodX;
          scan_done_d   = 1'b1;
          state_d       = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Pixel classification from committed registers only.
  always_comb begin
    disp_row_valid    = disp_row_q < Y_LIMIT;
    pix_flags.visible = bus.PixelValid && ({1'b0, bus.CellX} < X_LIMIT);
    pix_flags.border  = disp_row_valid &&
                        ((disp_row_q == '0) || (disp_row_q == Y_LAST) ||
                         (bus.CellX == '0) || (bus.CellX == X_LAST));
    pix_flags.food    = disp_food_q && (bus.CellX == disp_food_x_q);
    pix_flags.head    = disp_head_q[bus.CellX];
    pix_flags.body    = disp_body_q[bus.CellX];
  end

  cell_color_mux u_cell_color_mux (
    .flags (pix_flags),
    .color (pix_color)
  );

  always_comb begin
    rgb_d = pix_color;
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      row_q         <= '0;
      back_body_q   <= '0;
      back_head_q   <= '0;
      disp_body_q   <= '0;
      disp_head_q   <= '0;
      disp_row_q    <= Y_LIMIT;
      disp_food_q   <= 1'b0;
      disp_food_x_q <= '0;
      scan_done_q   <= 1'b0;
      rgb_q         <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      row_q         <= row_d;
      back_body_q   <= back_body_d;
      back_head_q   <= back_head_d;
      disp_body_q   <= disp_body_d;
      disp_head_q   <= disp_head_d;
      disp_row_q    <= disp_row_d;
      disp_food_q   <= disp_food_d;
      disp_food_x_q <= disp_food_x_d;
      scan_done_q   <= scan_done_d;
      rgb_q         <= rgb_d;
    end
  end

  assign bus.RGB      = rgb_q;
  assign bus.Busy     = (state_q != ST_IDLE);
  assign bus.ScanDone = scan_done_q;

endmodule

// File: tb/tb_snake_row_scanner.sv
module tb_snake_row_scanner;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  snake_row_scanner_if #(
    .GRID_WIDTH       (16),
    .GRID_HEIGHT      (12),
    .NUM_SNAKE_PIECES (8)
  ) bus ();

  snake_row_scanner #(
    .GRID_WIDTH       (16),
    .GRID_HEIGHT      (12),
    .NUM_SNAKE_PIECES (8)
  ) dut (
    .Clock  (clk),
    .ResetN (rst_n),
    .bus    (bus)
  );

  localparam logic [7:0] C_GREY = 8'b010_010_01;
  localparam logic [7:0] C_RED  = 8'b111_000_00;
  localparam logic [7:0] C_YEL  = 8'b111_111_00;
  localparam logic [7:0] C_GRN  = 8'b000_111_00;
  localparam logic [7:0] C_BLK  = 8'b000_000_00;

  int checks   = 0;
  int failures = 0;

  logic [3:0] sy [8];
  logic [3:0] sx [8];
  logic [3:0] fy, fx;

  // Reference model of the committed display state.
  int         model_row;
  logic       model_food_hit;
  int         model_food_x;
  logic [15:0] model_body, model_head;

  // Scoreboard for pixel lookups.
  logic [7:0] exp_q [$];
  string      tag_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < 8; i++) begin
      bus.packSnakeY[i*4 +: 4] = sy[i];
      bus.packSnakeX[i*4 +: 4] = sx[i];
    end
    bus.foodY = fy;
    bus.foodX = fx;
  endtask

  function automatic logic [7:0] model_rgb(input int x);
    bit rv;
    rv = (model_row < 12);
    if (x < 0 || x >= 16) return C_BLK;
    if (rv && (model_row == 0 || model_row == 11 || x == 0 || x == 15)) return C_GREY;
    if (model_food_hit && x == model_food_x) return C_RED;
    if (model_head[x]) return C_YEL;
    if (model_body[x]) return C_GRN;
    return C_BLK;
  endfunction

  task automatic model_commit(input int row);
    bit rv;
    rv = (row < 12);
    model_row      = row;
    model_food_hit = rv && (int'(fy) == row);
    model_food_x   = int'(fx);
    model_body     = '0;
    model_head     = '0;
    for (int i = 0; i < 8; i++) begin
      if (rv && int'(sy[i]) == row && sx[i] != 4'd0) begin
        model_body[sx[i]] = 1'b1;
        if (i == 0) model_head[sx[i]] = 1'b1;
      end
    end
  endtask

  task automatic model_reset();
    model_row      = 12;
    model_food_hit = 1'b0;
    model_food_x   = 0;
    model_body     = '0;
    model_head     = '0;
  endtask

  // Drive one pixel lookup; RGB must hold until the next edge, then show the result.
  task automatic pix(input logic valid, input int x, input string tag);
    logic [7:0] prev;
    prev = bus.RGB;
    bus.PixelValid = valid;
    bus.CellX      = 4'(x);
    exp_q.push_back(valid ? model_rgb(x) : C_BLK);
    tag_q.push_back(tag);
    #1;
    chk({tag, "_hold"}, 32'(bus.RGB), 32'(prev));
    @(posedge clk); #1;
    chk(tag_q.pop_front(), 32'(bus.RGB), 32'(exp_q.pop_front()));
  endtask

  task automatic sweep(input string name);
    for (int x = 0; x < 16; x++) pix(1'b1, x, $sformatf("%s_x%0d", name, x));
  endtask

  // Start a scan, optionally re-issue LineStart at cycle abort_at, and check
  // ScanDone timing, Busy, and that a probe pixel keeps the old colour
  // until the commit is visible.
  task automatic do_scan(input int row, input int abort_at, input int abort_row,
                         input int exp_done, input int probe, input string name);
    logic [7:0] old;
    int first;
    int pulses;
    first  = 0;
    pulses = 0;
    bus.PixelValid = 1'b1;
    bus.CellX      = 4'(probe);
    bus.LineStart  = 1'b1;
    bus.RowY       = 4'(row);
    old = model_rgb(probe);
    @(posedge clk); #1;
    bus.LineStart = 1'b0;
    chk({name, "_busy_start"}, 32'(bus.Busy), 32'd1);
    for (int k = 1; k <= exp_done + 3; k++) begin
      if (k == abort_at) begin
        bus.LineStart = 1'b1;
        bus.RowY      = 4'(abort_row);
      end
      @(posedge clk); #1;
      bus.LineStart = 1'b0;
      if (bus.ScanDone) begin
        pulses++;
        if (first == 0) first = k;
      end
      if (k <= exp_done) chk($sformatf("%s_probe_k%0d", name, k), 32'(bus.RGB), 32'(old));
      if (k == exp_done - 1) chk({name, "_busy_commit"}, 32'(bus.Busy), 32'd1);
      if (k == exp_done) chk({name, "_busy_done"}, 32'(bus.Busy), 32'd0);
    end
    chk({name, "_done_cycle"}, 32'(first), 32'(exp_done));
    chk({name, "_done_pulses"}, 32'(pulses), 32'd1);
    model_commit(abort_at > 0 ? abort_row : row);
    chk({name, "_probe_new"}, 32'(bus.RGB), 32'(model_rgb(probe)));
  endtask

  initial begin
    int pulses;
    for (int i = 0; i < 8; i++) begin
      sy[i] = 4'd0;
      sx[i] = 4'd0;
    end
    fy = 4'd9;
    fx = 4'd2;
    drive_inputs();
    bus.LineStart  = 1'b0;
    bus.RowY       = 4'd0;
    bus.PixelValid = 1'b0;
    bus.CellX      = 4'd0;
    model_reset();

    // Reset state
    #17;
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    chk("rst_done", 32'(bus.ScanDone), 32'd0);
    chk("rst_rgb", 32'(bus.RGB), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    sweep("after_reset");

    // Snake on row 5: head at 7, body at 6 and 5
    sy[0] = 4'd5; sx[0] = 4'd7;
    sy[1] = 4'd5; sx[1] = 4'd6;
    sy[2] = 4'd5; sx[2] = 4'd5;
    drive_inputs();
    do_scan(5, 0, 0, 9, 7, "row5");
    sweep("row5");

    // Food on a body cell wins over body
    fy = 4'd5; fx = 4'd5;
    drive_inputs();
    do_scan(5, 0, 0, 9, 5, "food");
    sweep("food");

    // Abort to row 3 at cycle 4
    sy[3] = 4'd3; sx[3] = 4'd9;
    drive_inputs();
    do_scan(5, 4, 3, 13, 7, "abort");
    sweep("row3");

    // Out-of-range row: no border, no pieces, no food
    sy[4] = 4'd12; sx[4] = 4'd3;
    fy = 4'd12; fx = 4'd8;
    drive_inputs();
    do_scan(12, 0, 0, 9, 3, "row12");
    sweep("row12");
    sy[4] = 4'd0; sx[4] = 4'd0;
    fy = 4'd5; fx = 4'd5;
    drive_inputs();

    // PixelValid low on the head cell
    do_scan(5, 0, 0, 9, 9, "rescan5");
    pix(1'b0, 7, "invalid_head");
    pix(1'b1, 7, "valid_head");
    pix(1'b0, 0, "invalid_border");

    // Reset in the middle of a scan
    bus.PixelValid = 1'b1;
    bus.CellX      = 4'd0;
    bus.LineStart  = 1'b1;
    bus.RowY       = 4'd3;
    @(posedge clk); #1;
    bus.LineStart = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_reset_rgb", 32'(bus.RGB), 32'(C_GREY));
    chk("pre_reset_busy", 32'(bus.Busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.Busy), 32'd0);
    chk("midrst_rgb", 32'(bus.RGB), 32'd0);
    chk("midrst_done", 32'(bus.ScanDone), 32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (bus.ScanDone) pulses++;
    end
    chk("post_reset_no_done", 32'(pulses), 32'd0);
    chk("post_reset_busy", 32'(bus.Busy), 32'd0);
    sweep("post_reset");
    do_scan(5, 0, 0, 9, 7, "clean5");
    sweep("clean5");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/snake_row_scanner.md
SNAKE_ROW_SCANNER -- requirements
Module: snake_row_scanner

Interface
REQ-001 SHALL have parameter GRID_WIDTH, default 16: grid columns.
REQ-002 SHALL have parameter GRID_HEIGHT, default 12: grid rows.
REQ-003 SHALL have parameter NUM_SNAKE_PIECES, default 8: packed piece count N.
REQ-004 SHALL have port Clock, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port ResetN, input, 1: asynchronous reset, active-low.
REQ-006 SHALL have port packSnakeY, input, YB*N: piece h Y bit k at [h*YB+k], YB=$clog2(GRID_HEIGHT).
REQ-007 SHALL have port packSnakeX, input, XB*N: same packing, XB=$clog2(GRID_WIDTH).
REQ-008 SHALL have ports foodY (YB bits) and foodX (XB bits), inputs: food cell.
REQ-009 SHALL have port LineStart, input, 1: one-cycle pulse requesting a scan of row RowY.
REQ-010 SHALL have port RowY, input, YB: grid row to scan, sampled when LineStart=1.
REQ-011 SHALL have ports PixelValid (input, 1) and CellX (input, XB): column of the current visible pixel.
REQ-012 SHALL have port RGB, output, [0:7]: 3-3-2 colour, registered.
REQ-013 SHALL have ports Busy (output, 1), high while scanning, and ScanDone (output, 1), a one-cycle commit pulse.

Function
REQ-014 SHALL implement FSM IDLE -> SCAN -> COMMIT -> IDLE.
REQ-015 In IDLE, LineStart SHALL latch RowY, clear the back bitmap and head bitmap, and enter SCAN.
REQ-016 SCAN SHALL examine one piece per cycle, index 0..N-1, in cycles 1..N after LineStart.
REQ-017 Piece i SHALL set back-bitmap bit X iff Y==latched row and X!=0; piece 0 SHALL additionally set the head bit.
REQ-018 COMMIT (cycle N+1) SHALL copy the back bitmaps, row and food match into the display registers atomically and pulse ScanDone.
REQ-019 Busy SHALL be 1 in SCAN and COMMIT and 0 otherwise.
REQ-020 LineStart during SCAN or COMMIT SHALL abort the scan without committing, relatch RowY and restart at piece 0; the display registers stay unchanged.
REQ-021 RowY >= GRID_HEIGHT SHALL still scan and commit, giving an all-zero row with no food.
REQ-022 RGB SHALL appear 1 cycle after PixelValid/CellX, with priority border > food > head > body > background.
REQ-023 Border SHALL be committed row 0 or GRID_HEIGHT-1, or CellX 0 or GRID_WIDTH-1; border colour SHALL be 8'b010_010_01.
REQ-024 Food SHALL be red 8'b111_000_00, head yellow 8'b111_111_00, body green 8'b000_111_00, background 8'b0.
REQ-025 PixelValid=0 or CellX >= GRID_WIDTH SHALL drive RGB=0 on the next cycle.
REQ-026 Pixel lookup SHALL use only the committed display registers, never the back bitmap under construction.
REQ-027 Inputs packSnakeY/X and foodY/X MAY change at any time; each piece SHALL be sampled in its own scan cycle.

Reset
REQ-028 ResetN=0 SHALL immediately force IDLE and clear Busy, ScanDone and RGB.
REQ-029 ResetN=0 SHALL also clear all bitmaps and latched rows, with committed row = GRID_HEIGHT so that no border is shown.
REQ-030 Reset mid-scan SHALL discard the scan with no ScanDone; the first LineStart after release starts a clean scan.

Structure
REQ-031 Colour constants, GRID_WIDTH, GRID_HEIGHT and NUM_SNAKE_PIECES SHALL live in shared Constants.v.
REQ-032 The priority colour select SHALL be one sub-module, cell_color_mux, which is combinational and whose output is registered by the parent.

Verification
REQ-033 Pieces (5,7),(5,6),(5,5), rest (0,0); LineStart RowY=5 -> ScanDone at cycle 9; CellX 7 yellow, 5/6 green, 4 black.
REQ-034 Food (5,5), piece 2 at (5,5) -> CellX 5 red (food beats body); CellX 0 and 15 grey.
REQ-035 LineStart RowY=5, then LineStart RowY=3 at cycle 4 -> one ScanDone, at cycle 13; display shows row 3 only.
REQ-036 LineStart RowY=12 -> ScanDone still pulses; all CellX black, no border.
REQ-037 ResetN low at cycle 3 of a scan -> Busy=0 and RGB=0 immediately; no ScanDone; next scan correct.
REQ-038 PixelValid=0 with CellX=7 on the head row, or CellX=20 -> RGB=0 one cycle later.
